// File: rtl/riscv_core_branch_redirect_ctrl_pkg.sv
// Shared types and constants for the EX-stage branch redirect controller.
package riscv_core_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    TRAP     = 2'd2
  } br_ctrl_state_e;

  localparam logic [3:0] EXC_INSTR_ADDR_MISALIGNED = 4'd0;

endpackage

// File: rtl/riscv_core_branch_mispredict_chk.sv
// Combinational compare of branch-unit verdict against the front-end prediction.
module riscv_core_branch_mispredict_chk #(
  parameter int XLEN = 64
) (
  input  logic            i_ex_istaken,
  input  logic [XLEN-1:0] i_ex_target,
  input  logic [XLEN-1:0] i_ex_fallthrough,
  input  logic            i_bp_taken,
  input  logic [XLEN-1:0] i_bp_target,
  output logic [XLEN-1:0] o_correct_pc,
  output logic            o_mispredict
);

  assign o_correct_pc = i_ex_istaken ? i_ex_target : i_ex_fallthrough;

  // Target only matters when the branch is actually taken.
  assign o_mispredict = (i_ex_istaken != i_bp_taken) ||
                        (i_ex_istaken && (i_ex_target != i_bp_target));

endmodule

// File: rtl/riscv_core_branch_redirect_ctrl.sv
// Branch resolution sequencer: redirect fetch, flush IF/ID or raise a misaligned trap.
// Optional performance counters are built when RISCV_CORE_BRANCH_PERF_EN is defined.
module riscv_core_branch_redirect_ctrl
  import riscv_core_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ex_valid,
  input  logic            i_ex_istaken,
  input  logic            i_ex_addr_mismatch,
  input  logic [XLEN-1:0] i_ex_target,
  input  logic [XLEN-1:0] i_ex_fallthrough,
  input  logic            i_bp_taken,
  input  logic [XLEN-1:0] i_bp_target,
  input  logic            i_pipe_kill,
  input  logic            i_redirect_ready,
  input  logic            i_trap_ready,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_flush,
  output logic            o_ex_stall,
  output logic            o_trap_valid,
  output logic [3:0]      o_trap_cause,
  output logic [XLEN-1:0] o_trap_tval
`ifdef RISCV_CORE_BRANCH_PERF_EN
  ,
  output logic [CNT_W-1:0] o_perf_branches,
  output logic [CNT_W-1:0] o_perf_mispredicts
`endif
);

  br_ctrl_state_e  r_state, w_state_next;
  logic [XLEN-1:0] w_correct_pc;
  logic            w_mispredict;
  logic            w_resolve;

  logic            r_redirect_valid, w_redirect_valid_n;
  logic [XLEN-1:0] r_redirect_pc,    w_redirect_pc_n;
  logic            r_flush,          w_flush_n;
  logic            r_trap_valid,     w_trap_valid_n;
  logic [3:0]      r_trap_cause,     w_trap_cause_n;
  logic [XLEN-1:0] r_trap_tval,      w_trap_tval_n;

  riscv_core_branch_mispredict_chk #(.XLEN(XLEN)) u_chk (
    .i_ex_istaken     (i_ex_istaken),
    .i_ex_target      (i_ex_target),
    .i_ex_fallthrough (i_ex_fallthrough),
    .i_bp_taken       (i_bp_taken),
    .i_bp_target      (i_bp_target),
    .o_correct_pc     (w_correct_pc),
    .o_mispredict     (w_mispredict)
  );

  assign w_resolve = (r_state == IDLE) && i_ex_valid && !i_pipe_kill;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    if (i_pipe_kill) begin
      w_state_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_resolve && i_ex_addr_mismatch) w_state_next = TRAP;
          else if (w_resolve && w_mispredict)  w_state_next = REDIRECT;
        end
        REDIRECT: if (i_redirect_ready) w_state_next = IDLE;
        TRAP:     if (i_trap_ready)     w_state_next = IDLE;
        default:  w_state_next = IDLE;
      endcase
    end
  end

  // Request payloads are captured on entry, held while waiting, and cleared on exit.
  always_comb begin
    w_redirect_valid_n = (w_state_next == REDIRECT);
    w_trap_valid_n     = (w_state_next == TRAP);
    w_flush_n          = (r_state == IDLE) && (w_state_next != IDLE);
    w_redirect_pc_n    = '0;
    w_trap_tval_n      = '0;
    w_trap_cause_n     = '0;
    if (w_state_next == REDIRECT)
      w_redirect_pc_n = (r_state == IDLE) ? w_correct_pc : r_redirect_pc;
    if (w_state_next == TRAP) begin
      w_trap_tval_n  = (r_state == IDLE) ? i_ex_target : r_trap_tval;
      w_trap_cause_n = EXC_INSTR_ADDR_MISALIGNED;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_flush          <= 1'b0;
      r_trap_valid     <= 1'b0;
      r_trap_cause     <= '0;
      r_trap_tval      <= '0;
    end else begin
      r_redirect_valid <= w_redirect_valid_n;
      r_redirect_pc    <= w_redirect_pc_n;
      r_flush          <= w_flush_n;
      r_trap_valid     <= w_trap_valid_n;
      r_trap_cause     <= w_trap_cause_n;
      r_trap_tval      <= w_trap_tval_n;
    end
  end

  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;
  assign o_flush          = r_flush;
  assign o_trap_valid     = r_trap_valid;
  assign o_trap_cause     = r_trap_cause;
  assign o_trap_tval      = r_trap_tval;
  assign o_ex_stall       = (r_state != IDLE);

`ifdef RISCV_CORE_BRANCH_PERF_EN
  logic [CNT_W-1:0] r_perf_branches;
  logic [CNT_W-1:0] r_perf_mispredicts;

  // Misaligned resolutions count as branches but never as mispredicts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_perf_branches    <= '0;
      r_perf_mispredicts <= '0;
    end else if (w_resolve) begin
      r_perf_branches <= r_perf_branches + 1'b1;
      if (!i_ex_addr_mismatch && w_mispredict)
        r_perf_mispredicts <= r_perf_mispredicts + 1'b1;
    end
  end

  assign o_perf_branches    = r_perf_branches;
  assign o_perf_mispredicts = r_perf_mispredicts;
`endif

endmodule

// File: doc/riscv_core_branch_redirect_ctrl.md
Name: riscv_core_branch_redirect_ctrl

Overview:
- Sequences branch resolution in EX.
- Consumes the branch-unit verdict (taken, misaligned target) and the front-end prediction, and decides whether to redirect fetch, flush IF/ID, or raise an instruction-address-misaligned trap.
- Holds EX stalled until the fetch unit or the CSR/trap unit accepts the request.
- Sits between the EX-stage branch unit, the fetch PC mux and the CSR trap logic.

Parameters:
- XLEN, 64, datapath/PC width.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- i_clk  in  1  core clock.
- i_rst  in  1  asynchronous active-high reset.
- i_ex_valid  in  1  EX holds a valid control-transfer instruction this cycle.
- i_ex_istaken  in  1  branch-unit taken verdict; jumps drive 1.
- i_ex_addr_mismatch  in  1  branch-unit misaligned-target flag.
- i_ex_target  in  XLEN  computed taken target.
- i_ex_fallthrough  in  XLEN  PC+4, or PC+2 when compressed; supplied by the decode path.
- i_bp_taken  in  1  prediction carried down the pipe.
- i_bp_target  in  XLEN  predicted target.
- i_pipe_kill  in  1  older-instruction trap or interrupt; aborts any pending action.
- i_redirect_ready  in  1  fetch accepts the redirect.
- i_trap_ready  in  1  CSR unit accepts the trap.
- o_redirect_valid  out  1  redirect request.
- o_redirect_pc  out  XLEN  corrected PC.
- o_flush  out  1  one-cycle flush of IF/ID.
- o_ex_stall  out  1  hold EX and upstream stages.
- o_trap_valid  out  1  trap request.
- o_trap_cause  out  4  exception code; always 4'd0, instruction address misaligned.
- o_trap_tval  out  XLEN  faulting target.

Behaviour:
- Reset value of every output is 0. FSM state resets to IDLE.
- FSM states: IDLE, REDIRECT, TRAP. Encoding is an enum in the package.
- Resolution happens in IDLE when i_ex_valid=1 and i_pipe_kill=0. Resolutions outside IDLE are ignored; EX is stalled, so the instruction is held upstream.
- Correct PC = i_ex_istaken ? i_ex_target : i_ex_fallthrough.
- Mispredict = (i_ex_istaken != i_bp_taken) OR (i_ex_istaken AND i_ex_target != i_bp_target). Full-width equality compare.
- Priority at resolution: misaligned over mispredict.
  - i_ex_addr_mismatch=1: next cycle o_trap_valid=1, o_trap_tval=i_ex_target, o_flush=1 for that one cycle; go to TRAP.
  - Else mispredict: next cycle o_redirect_valid=1, o_redirect_pc=correct PC, o_flush=1 for that one cycle; go to REDIRECT.
  - Else (correct prediction): stay in IDLE, no outputs.
- Latency: resolution to request/flush is exactly 1 cycle. All outputs are registered.
- o_ex_stall = (state != IDLE). It is combinational from state.
- REDIRECT state:
  - o_redirect_valid and o_redirect_pc are held stable until i_redirect_ready=1.
  - The handshake completes in the cycle valid&ready are both high; o_redirect_valid drops and the FSM returns to IDLE the next cycle.
- TRAP state:
  - o_trap_valid, o_trap_cause and o_trap_tval are held stable until i_trap_ready=1; then go to IDLE.
  - o_redirect_valid stays 0 in TRAP; the CSR unit owns the trap vector.
- i_pipe_kill in any state:
  - Next cycle all request outputs are 0 and state is IDLE.
  - If kill coincides with ready, kill wins and no further action is taken.
  - Kill coinciding with a resolution in IDLE discards the resolution.
- o_flush never asserts for two consecutive cycles. A new resolution is impossible until the FSM is back in IDLE.
- Asynchronous reset mid-handshake: all outputs drop immediately and the request is lost by design.

Optional Feature:
- Macro: RISCV_CORE_BRANCH_PERF_EN.
- With the macro defined:
  - Adds outputs o_perf_branches [CNT_W] and o_perf_mispredicts [CNT_W].
  - Branches increments on every accepted resolution.
  - Mispredicts increments on every resolution that enters REDIRECT. Misaligned resolutions are not counted as mispredicts.
  - Both counters reset to 0, wrap modulo 2^CNT_W, and do not count killed resolutions.
- Without the macro: the ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Package riscv_core_pkg holds:
  - the FSM state enum br_ctrl_state_e;
  - the constant EXC_INSTR_ADDR_MISALIGNED = 4'd0.
- One natural sub-module: riscv_core_branch_mispredict_chk, combinational. It computes the correct PC and the mispredict flag from the verdict and prediction.
- The FSM and output registers stay in the top module.

Test Plan:
- Correct not-taken: i_ex_istaken=0, i_bp_taken=0 → no flush, no stall, IDLE maintained; counters (if enabled) read branches=1, mispredicts=0.
- Taken, predicted not-taken: target=0x1000, fallthrough=0x0FFC+4 → 1 cycle later o_flush=1 for one cycle and o_redirect_valid=1 with pc=0x1000. Hold i_redirect_ready=0 for 3 cycles: pc stays stable and o_ex_stall=1. Ready then gives valid=0 on the next cycle.
- Taken with matching direction but wrong target: i_bp_target=0x2000, i_ex_target=0x2040 → redirect to 0x2040.
- Misaligned plus mispredict in the same cycle: target=0x3001, mismatch=1 → o_trap_valid=1, tval=0x3001, cause=0, no redirect. i_trap_ready then returns the FSM to IDLE.
- i_pipe_kill asserted in REDIRECT together with i_redirect_ready=1 → next cycle all outputs 0 and IDLE; no extra flush.
- Assert i_rst asynchronously mid-TRAP → o_trap_valid and o_ex_stall go to 0 without waiting for a clock edge.
